// File: rtl/abm_ram_writer_if.sv
// AXI4 write-only channel bundle (AW/W/B) between the host interconnect and abm_ram_writer.
// The read channels live on the separate ABM manager block.
interface abm_ram_writer_if #(
  parameter int unsigned DW = 512
);
  localparam int unsigned SW = DW / 8;

  logic [31:0]   awaddr;
  logic          awvalid;
  logic          awready;
  logic [3:0]    awid;
  logic [7:0]    awlen;
  logic [2:0]    awsize;
  logic [1:0]    awburst;
  logic          awlock;
  logic [3:0]    awcache;
  logic [3:0]    awqos;
  logic [2:0]    awprot;

  logic [DW-1:0] wdata;
  logic [SW-1:0] wstrb;
  logic          wlast;
  logic          wvalid;
  logic          wready;

  logic [3:0]    bid;
  logic [1:0]    bresp;
  logic          bvalid;
  logic          bready;

  modport master (
    output awaddr, awvalid, awid, awlen, awsize, awburst, awlock, awcache, awqos, awprot,
    output wdata, wstrb, wlast, wvalid,
    output bready,
    input  awready, wready, bid, bresp, bvalid
  );

  modport slave (
    input  awaddr, awvalid, awid, awlen, awsize, awburst, awlock, awcache, awqos, awprot,
    input  wdata, wstrb, wlast, wvalid,
    input  bready,
    output awready, wready, bid, bresp, bvalid
  );
endinterface

// File: rtl/abm_ram_writer.sv
// abm_ram_writer: AXI4 write-only slave driving registered, byte-enabled writes into an ABM RAM.
// Define ABM_WLAST_CHECK_EN to check WLAST per beat and answer SLVERR on a framing mismatch.
module abm_ram_writer #(
  parameter int unsigned DW = 512,
  parameter int unsigned AW = 10
) (
  input  logic              clk,
  input  logic              resetn,
  abm_ram_writer_if.slave   s_axi,
  output logic [AW-1:0]     ram_waddr,
  output logic [DW-1:0]     ram_wdata,
  output logic [DW/8-1:0]   ram_wbe
);
  localparam int unsigned SW         = DW / 8;
  localparam int unsigned BSHIFT     = $clog2(SW);
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    RESET_WAIT = 2'd0,
    ADDR       = 2'd1,
    DATA       = 2'd2,
    RESP       = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic          rst_seen_q, rst_seen_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [7:0]    len_q, len_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          err_q, err_d;

  logic          awready_q, awready_d;
  logic          wready_q, wready_d;
  logic          bvalid_q, bvalid_d;
  logic [1:0]    bresp_q, bresp_d;
  logic [3:0]    bid_q, bid_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [SW-1:0] wbe_q, wbe_d;

  logic          last_beat;
  logic          beat_err;

  // Fields accepted for protocol compliance only: full-width INCR bursts are assumed.
  logic unused_ok;
  assign unused_ok = ^{s_axi.awsize, s_axi.awburst, s_axi.awlock, s_axi.awcache,
                       s_axi.awqos, s_axi.awprot, s_axi.awaddr, s_axi.wlast};

  always_comb begin
    state_d    = state_q;
    rst_seen_d = rst_seen_q;
    addr_d     = addr_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    awready_d  = awready_q;
    wready_d   = wready_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    bid_d      = bid_q;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    wbe_d      = '0;

    last_beat  = (cnt_q == len_q);
    beat_err   = 1'b0;
`ifdef ABM_WLAST_CHECK_EN
    beat_err   = (s_axi.wlast != last_beat);
`endif

    case (state_q)
      // One idle cycle after reset release before the first AW can be taken.
      RESET_WAIT: begin
        rst_seen_d = 1'b1;
        if (rst_seen_q) begin
          awready_d = 1'b1;
          state_d   = ADDR;
        end
      end
      ADDR: begin
        if (s_axi.awvalid && awready_q) begin
          addr_d    = AW'(s_axi.awaddr >> BSHIFT);
          len_d     = s_axi.awlen;
          bid_d     = s_axi.awid;
          cnt_d     = 8'd0;
          err_d     = 1'b0;
          awready_d = 1'b0;
          wready_d  = 1'b1;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (s_axi.wvalid && wready_q) begin
          waddr_d = addr_q;
          wdata_d = s_axi.wdata;
          wbe_d   = s_axi.wstrb;
          addr_d  = addr_q + AW'(1);
          cnt_d   = cnt_q + 8'd1;
          err_d   = err_q | beat_err;
          // Burst length comes from AWLEN alone; WLAST only affects the response.
          if (last_beat) begin
            wready_d = 1'b0;
            bvalid_d = 1'b1;
            bresp_d  = (err_q | beat_err) ? RESP_SLVERR : RESP_OKAY;
            state_d  = RESP;
          end
        end
      end
      RESP: begin
        if (s_axi.bready && bvalid_q) begin
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          state_d   = ADDR;
        end
      end
      default: state_d = RESET_WAIT;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= RESET_WAIT;
      rst_seen_q <= 1'b0;
      addr_q     <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= '0;
      bid_q      <= '0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      wbe_q      <= '0;
    end else begin
      state_q    <= state_d;
      rst_seen_q <= rst_seen_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      bid_q      <= bid_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      wbe_q      <= wbe_d;
    end
  end

  assign s_axi.awready = awready_q;
  assign s_axi.wready  = wready_q;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bresp   = bresp_q;
  assign s_axi.bid     = bid_q;
  assign ram_waddr     = waddr_q;
  assign ram_wdata     = wdata_q;
  assign ram_wbe       = wbe_q;
endmodule

// File: tb/tb_abm_ram_writer.sv
// Bench for abm_ram_writer: random bursts checked against an address/timing model of the AXI write path.
`timescale 1ns/1ps
module tb_abm_ram_writer;
  localparam int unsigned DW = 512;
  localparam int unsigned AW = 10;
  localparam int unsigned SW = DW / 8;

  logic          clk = 1'b0;
  logic          resetn;
  logic [AW-1:0] ram_waddr;
  logic [DW-1:0] ram_wdata;
  logic [SW-1:0] ram_wbe;

  abm_ram_writer_if #(.DW(DW)) s_axi ();

  abm_ram_writer #(.DW(DW), .AW(AW)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .s_axi     (s_axi),
    .ram_waddr (ram_waddr),
    .ram_wdata (ram_wdata),
    .ram_wbe   (ram_wbe)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            cyc;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [SW-1:0] wbe;
  } wr_t;

  wr_t wq[$];

  // Every cycle with any byte enable set is one RAM write.
  always @(negedge clk) begin
    wr_t r;
    if (ram_wbe !== '0) begin
      r.cyc  = cyc;
      r.addr = ram_waddr;
      r.data = ram_wdata;
      r.wbe  = ram_wbe;
      wq.push_back(r);
    end
  end

  int n_checks;
  int n_fail;

  logic [DW-1:0] bd_data [0:255];
  logic [SW-1:0] bd_strb [0:255];
  int            aw_cyc, b_first_cyc, b_hold_err, wready_drop, aw_during;
  logic          wr_after_aw, awr_after_aw, aw_after_b, bv_after_b;
  logic [1:0]    bresp_seen;
  logic [3:0]    bid_seen;

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] w;
    for (int i = 0; i < int'(DW / 32); i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  function automatic logic [SW-1:0] rand_strb();
    logic [SW-1:0] s;
    for (int i = 0; i < int'(SW / 32); i++) s[i*32 +: 32] = $urandom;
    if (s == '0) s[0] = 1'b1;
    return s;
  endfunction

  function automatic logic [AW-1:0] model_addr(input logic [31:0] a, input int beat);
    longint unsigned w;
    w = (longint'(a) / SW + longint'(beat)) % (longint'(1) << AW);
    return AW'(w);
  endfunction

  function automatic logic [1:0] model_bresp(input int bad);
`ifdef ABM_WLAST_CHECK_EN
    return (bad >= 0) ? 2'd2 : 2'd0;
`else
    return (bad >= 0) ? 2'd0 : 2'd0;
`endif
  endfunction

  task automatic idle_inputs();
    s_axi.awaddr = '0; s_axi.awvalid = 1'b0; s_axi.awid = '0; s_axi.awlen = '0;
    s_axi.awsize = '0; s_axi.awburst = '0; s_axi.awlock = 1'b0; s_axi.awcache = '0;
    s_axi.awqos = '0; s_axi.awprot = '0;
    s_axi.wdata = '0; s_axi.wstrb = '0; s_axi.wlast = 1'b0; s_axi.wvalid = 1'b0;
    s_axi.bready = 1'b0;
  endtask

  task automatic drive_aw(input logic [31:0] a, input int len, input logic [3:0] id);
    int to;
    s_axi.awaddr  = a;        s_axi.awlen   = 8'(len);    s_axi.awid = id;
    s_axi.awsize  = 3'($urandom); s_axi.awburst = 2'($urandom); s_axi.awlock = 1'($urandom);
    s_axi.awcache = 4'($urandom); s_axi.awqos   = 4'($urandom); s_axi.awprot = 3'($urandom);
    s_axi.awvalid = 1'b1;
    to = 0;
    while (!s_axi.awready && to < 64) begin @(negedge clk); to++; end
    if (!s_axi.awready) begin
      n_checks++; n_fail++;
      $display("FAIL aw_timeout: awready=%0b after %0d cycles, required 1", s_axi.awready, to);
    end
    aw_cyc = cyc + 1;
    @(negedge clk);
    s_axi.awvalid = 1'b0;
    wr_after_aw   = s_axi.wready;
    awr_after_aw  = s_axi.awready;
  endtask

  task automatic drive_w(input int nbeats, input int len, input bit gap, input bit rnd_strb, input int bad);
    int b, to;
    bit idle;
    for (int i = 0; i < nbeats; i++) begin
      bd_data[i] = rand_word();
      bd_strb[i] = rnd_strb ? rand_strb() : '1;
    end
    b = 0; to = 0; idle = 1'b0; wready_drop = 0; aw_during = 0;
    while (b < nbeats && to < 2000) begin
      if (!s_axi.wready) wready_drop++;
      if (s_axi.awready) aw_during++;
      if (gap && idle) begin
        s_axi.wvalid = 1'b0;
      end else begin
        s_axi.wdata  = bd_data[b];
        s_axi.wstrb  = bd_strb[b];
        s_axi.wlast  = ((b == len) != (b == bad));
        s_axi.wvalid = 1'b1;
        if (s_axi.wready) b++;
      end
      idle = ~idle;
      to++;
      @(negedge clk);
    end
    s_axi.wvalid = 1'b0;
    s_axi.wlast  = 1'b0;
    if (b < nbeats) begin
      n_checks++; n_fail++;
      $display("FAIL w_timeout: %0d beats accepted, required %0d", b, nbeats);
    end
  endtask

  task automatic handle_b(input int delay);
    int to;
    to = 0;
    while (!s_axi.bvalid && to < 64) begin @(negedge clk); to++; end
    if (!s_axi.bvalid) begin
      n_checks++; n_fail++;
      $display("FAIL b_timeout: bvalid=%0b after %0d cycles, required 1", s_axi.bvalid, to);
    end
    b_first_cyc = cyc;
    bresp_seen  = s_axi.bresp;
    bid_seen    = s_axi.bid;
    b_hold_err  = 0;
    for (int k = 0; k < delay; k++) begin
      @(negedge clk);
      if (!s_axi.bvalid || s_axi.awready || s_axi.bresp !== bresp_seen) b_hold_err++;
    end
    s_axi.bready = 1'b1;
    @(negedge clk);
    s_axi.bready = 1'b0;
    aw_after_b = s_axi.awready;
    bv_after_b = s_axi.bvalid;
  endtask

  task automatic test_reset();
    int r;
    idle_inputs();
    resetn = 1'b1;
    #1 resetn = 1'b0;
    #2;
    n_checks++;
    if ({s_axi.awready, s_axi.wready, s_axi.bvalid, s_axi.bresp, s_axi.bid} !== 9'd0 ||
        ram_wbe !== '0 || ram_waddr !== '0 || ram_wdata !== '0) begin
      n_fail++;
      $display("FAIL reset_values: awready=%b wready=%b bvalid=%b bresp=%0d bid=%0d wbe_zero=%b waddr=%0d, required all 0",
               s_axi.awready, s_axi.wready, s_axi.bvalid, s_axi.bresp, s_axi.bid, ram_wbe == '0, ram_waddr);
    end
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    r = cyc;
    @(negedge clk);
    n_checks++;
    if (s_axi.awready !== 1'b0) begin
      n_fail++; $display("FAIL reset_awready_early: awready=%b one edge after release, required 0", s_axi.awready);
    end
    @(negedge clk);
    n_checks++;
    if (s_axi.awready !== 1'b1 || cyc != r + 2) begin
      n_fail++; $display("FAIL reset_awready: awready=%b at edge %0d, required 1 at edge %0d", s_axi.awready, cyc - r, 2);
    end
  endtask

  task automatic test_single_beat();
    logic [3:0] id;
    id = 4'($urandom_range(1, 15));
    wq.delete();
    drive_aw(32'h40, 0, id);
    n_checks++;
    if (wr_after_aw !== 1'b1 || awr_after_aw !== 1'b0) begin
      n_fail++; $display("FAIL single_aw_accept: wready=%b awready=%b, required 1 0", wr_after_aw, awr_after_aw);
    end
    drive_w(1, 0, 1'b0, 1'b0, -1);
    handle_b(0);
    n_checks++;
    if (wq.size() != 1) begin
      n_fail++; $display("FAIL single_count: %0d writes, required 1", wq.size());
    end else begin
      n_checks++;
      if (wq[0].addr !== 10'd1 || wq[0].wbe !== {SW{1'b1}} || wq[0].data !== bd_data[0] || wq[0].cyc != aw_cyc + 1) begin
        n_fail++;
        $display("FAIL single_write: addr=%0d wbe=%h cyc=%0d data_ok=%b, required addr=1 wbe=all-ones cyc=%0d",
                 wq[0].addr, wq[0].wbe, wq[0].cyc, wq[0].data === bd_data[0], aw_cyc + 1);
      end
    end
    n_checks++;
    if (b_first_cyc != aw_cyc + 1 || bresp_seen !== 2'd0 || bid_seen !== id) begin
      n_fail++;
      $display("FAIL single_bresp: bvalid_cyc=%0d bresp=%0d bid=%0d, required cyc=%0d bresp=0 bid=%0d",
               b_first_cyc, bresp_seen, bid_seen, aw_cyc + 1, id);
    end
  endtask

  task automatic test_burst_no_bubble();
    wq.delete();
    drive_aw(32'h0, 3, 4'h3);
    drive_w(4, 3, 1'b0, 1'b0, -1);
    handle_b(0);
    n_checks++;
    if (wq.size() != 4) begin
      n_fail++; $display("FAIL burst4_count: %0d writes, required 4", wq.size());
    end
    for (int b = 0; b < wq.size() && b < 4; b++) begin
      n_checks++;
      if (wq[b].addr !== AW'(b) || wq[b].cyc != aw_cyc + 1 + b || wq[b].data !== bd_data[b]) begin
        n_fail++;
        $display("FAIL burst4_beat%0d: addr=%0d cyc=%0d data_ok=%b, required addr=%0d cyc=%0d",
                 b, wq[b].addr, wq[b].cyc, wq[b].data === bd_data[b], b, aw_cyc + 1 + b);
      end
    end
    n_checks++;
    if (b_first_cyc != aw_cyc + 4 || wready_drop != 0) begin
      n_fail++;
      $display("FAIL burst4_bvalid: bvalid_cyc=%0d wready_drops=%0d, required cyc=%0d drops=0",
               b_first_cyc, wready_drop, aw_cyc + 4);
    end
  endtask

  task automatic test_gapped_strobes();
    logic [31:0] a;
    int len;
    wq.delete();
    a   = $urandom;
    len = $urandom_range(2, 7);
    drive_aw(a, len, 4'h7);
    drive_w(len + 1, len, 1'b1, 1'b1, -1);
    handle_b(0);
    n_checks++;
    if (wq.size() != len + 1) begin
      n_fail++; $display("FAIL gap_count: %0d writes, required %0d", wq.size(), len + 1);
    end
    for (int b = 0; b < wq.size() && b <= len; b++) begin
      n_checks++;
      if (wq[b].addr !== model_addr(a, b) || wq[b].wbe !== bd_strb[b] ||
          wq[b].data !== bd_data[b] || wq[b].cyc != aw_cyc + 1 + 2 * b) begin
        n_fail++;
        $display("FAIL gap_beat%0d: addr=%0d wbe=%h cyc=%0d data_ok=%b, required addr=%0d wbe=%h cyc=%0d",
                 b, wq[b].addr, wq[b].wbe, wq[b].cyc, wq[b].data === bd_data[b],
                 model_addr(a, b), bd_strb[b], aw_cyc + 1 + 2 * b);
      end
    end
    n_checks++;
    if (wready_drop != 0 || b_first_cyc != aw_cyc + 1 + 2 * len) begin
      n_fail++;
      $display("FAIL gap_wready: drops=%0d bvalid_cyc=%0d, required drops=0 cyc=%0d",
               wready_drop, b_first_cyc, aw_cyc + 1 + 2 * len);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] a;
    int exp_addr [4];
    a = 32'd1022 * SW;
    exp_addr = '{1022, 1023, 0, 1};
    wq.delete();
    drive_aw(a, 3, 4'h9);
    drive_w(4, 3, 1'b0, 1'b1, -1);
    handle_b(0);
    n_checks++;
    if (wq.size() != 4) begin
      n_fail++; $display("FAIL wrap_count: %0d writes, required 4", wq.size());
    end
    for (int b = 0; b < wq.size() && b < 4; b++) begin
      n_checks++;
      if (wq[b].addr !== AW'(exp_addr[b]) || wq[b].wbe !== bd_strb[b]) begin
        n_fail++;
        $display("FAIL wrap_beat%0d: addr=%0d wbe=%h, required addr=%0d wbe=%h",
                 b, wq[b].addr, wq[b].wbe, exp_addr[b], bd_strb[b]);
      end
    end
  endtask

  task automatic test_bready_hold();
    wq.delete();
    drive_aw($urandom, 1, 4'hC);
    drive_w(2, 1, 1'b0, 1'b1, -1);
    handle_b(5);
    n_checks++;
    if (b_hold_err != 0) begin
      n_fail++; $display("FAIL bhold_stable: %0d bad cycles while BREADY low, required 0", b_hold_err);
    end
    n_checks++;
    if (aw_after_b !== 1'b1 || bv_after_b !== 1'b0) begin
      n_fail++; $display("FAIL bhold_release: awready=%b bvalid=%b after B handshake, required 1 0", aw_after_b, bv_after_b);
    end
  endtask

  task automatic test_wlast();
    for (int bad = 0; bad < 2; bad++) begin
      wq.delete();
      drive_aw($urandom, 1, 4'h5);
      drive_w(2, 1, 1'b0, 1'b0, bad);
      handle_b(0);
      n_checks++;
      if (bresp_seen !== model_bresp(bad) || wq.size() != 2) begin
        n_fail++;
        $display("FAIL wlast_bad%0d: bresp=%0d writes=%0d, required bresp=%0d writes=2",
                 bad, bresp_seen, wq.size(), model_bresp(bad));
      end
    end
  endtask

  task automatic test_random_bursts();
    logic [31:0] a;
    logic [3:0]  id;
    int len, bad, stride, delay;
    bit gap;
    for (int n = 0; n < 12; n++) begin
      a     = $urandom;
      id    = 4'($urandom);
      len   = $urandom_range(0, 15);
      gap   = 1'($urandom);
      delay = $urandom_range(0, 3);
      bad   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, len)) : -1;
      stride = gap ? 2 : 1;
      wq.delete();
      drive_aw(a, len, id);
      drive_w(len + 1, len, gap, 1'b1, bad);
      handle_b(delay);
      n_checks++;
      if (wq.size() != len + 1 || aw_during != 0) begin
        n_fail++; $display("FAIL rnd%0d_count: %0d writes awready_in_data=%0d, required %0d and 0", n, wq.size(), aw_during, len + 1);
      end
      for (int b = 0; b < wq.size() && b <= len; b++) begin
        n_checks++;
        if (wq[b].addr !== model_addr(a, b) || wq[b].wbe !== bd_strb[b] ||
            wq[b].data !== bd_data[b] || wq[b].cyc != aw_cyc + 1 + stride * b) begin
          n_fail++;
          $display("FAIL rnd%0d_beat%0d: addr=%0d wbe=%h cyc=%0d data_ok=%b, required addr=%0d wbe=%h cyc=%0d",
                   n, b, wq[b].addr, wq[b].wbe, wq[b].cyc, wq[b].data === bd_data[b],
                   model_addr(a, b), bd_strb[b], aw_cyc + 1 + stride * b);
        end
      end
      n_checks++;
      if (b_first_cyc != aw_cyc + 1 + stride * len || bresp_seen !== model_bresp(bad) ||
          bid_seen !== id || b_hold_err != 0 || aw_after_b !== 1'b1) begin
        n_fail++;
        $display("FAIL rnd%0d_resp: bvalid_cyc=%0d bresp=%0d bid=%0d hold_err=%0d awready=%b, required cyc=%0d bresp=%0d bid=%0d 0 1",
                 n, b_first_cyc, bresp_seen, bid_seen, b_hold_err, aw_after_b,
                 aw_cyc + 1 + stride * len, model_bresp(bad), id);
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    int r;
    logic was_writing;
    wq.delete();
    drive_aw(32'h200, 7, 4'hA);
    drive_w(3, 7, 1'b0, 1'b1, -1);
    was_writing = (ram_wbe !== '0) && s_axi.wready;
    #2 resetn = 1'b0;
    #1;
    n_checks++;
    if (!was_writing ||
        {s_axi.awready, s_axi.wready, s_axi.bvalid, s_axi.bresp, s_axi.bid} !== 9'd0 ||
        ram_wbe !== '0 || ram_waddr !== '0 || ram_wdata !== '0) begin
      n_fail++;
      $display("FAIL midrst_values: mid_burst=%b awready=%b wready=%b bvalid=%b bid=%0d waddr=%0d wbe_zero=%b, required 1 then all 0",
               was_writing, s_axi.awready, s_axi.wready, s_axi.bvalid, s_axi.bid, ram_waddr, ram_wbe == '0);
    end
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    r = cyc;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (s_axi.awready !== 1'b1 || s_axi.bvalid !== 1'b0 || cyc != r + 2 || wq.size() != 3) begin
      n_fail++;
      $display("FAIL midrst_recover: awready=%b bvalid=%b writes=%0d, required 1 0 3", s_axi.awready, s_axi.bvalid, wq.size());
    end
    wq.delete();
    drive_aw(32'h0, 1, 4'h6);
    drive_w(2, 1, 1'b0, 1'b0, -1);
    handle_b(0);
    n_checks++;
    if (wq.size() != 2 || bresp_seen !== 2'd0 || bid_seen !== 4'h6) begin
      n_fail++;
      $display("FAIL midrst_next: writes=%0d bresp=%0d bid=%0d, required 2 0 6", wq.size(), bresp_seen, bid_seen);
    end else begin
      n_checks++;
      if (wq[0].addr !== 10'd0 || wq[1].addr !== 10'd1) begin
        n_fail++; $display("FAIL midrst_addr: addr=%0d,%0d, required 0,1", wq[0].addr, wq[1].addr);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_single_beat();
    test_burst_no_bubble();
    test_gapped_strobes();
    test_wrap();
    test_bready_hold();
    test_wlast();
    test_random_bursts();
    test_reset_mid_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end
endmodule
